// File: rtl/fifo_wr_arb_if.sv
// Requester streams and FIFO write port shared by the round-robin write arbiter.
// The arbiter connects through the slave modport; whatever drives it uses master.
interface fifo_wr_arb_if #(
    parameter int REQ_N  = 4,
    parameter int DATA_W = 8
);
    logic [REQ_N-1:0]        req_valid;
    logic [REQ_N*DATA_W-1:0] req_data;
    logic [REQ_N-1:0]        req_last;
    logic [REQ_N-1:0]        req_ready;
    logic                    fifo_full;
    logic                    fifo_wr;
    logic [DATA_W-1:0]       fifo_wr_data;
    logic [REQ_N-1:0]        lock;
    logic                    busy;

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr, fifo_wr_data, lock, busy
    );

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr, fifo_wr_data, lock, busy
    );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port between REQ_N valid/ready/last streams.
// A packet holds the port until its last beat or until BURST_MAX beats have gone through.
//
// state  | meaning
// IDLE   | pick the first valid requester at or after rr_ptr, one beat per grant
// LOCKED | owner keeps the port for the rest of its packet, others are ignored
module fifo_wr_arb #(
    parameter int REQ_N     = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          nreset,
    fifo_wr_arb_if.slave  bus
);
    localparam int PW = (REQ_N > 1) ? $clog2(REQ_N) : 1;
    localparam int CW = (BURST_MAX > 0) ? $clog2(BURST_MAX + 1) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    rr_ptr, rr_ptr_nxt;
    logic [PW-1:0]    owner, owner_nxt;
    logic [CW-1:0]    beat_cnt, beat_cnt_nxt;

    logic [PW-1:0]    winner;
    logic             found;
    logic [PW-1:0]    sel;
    logic             sel_ok;
    logic             grant_ready;
    logic             xfer;
    logic [REQ_N-1:0] ready_vec;
    logic [REQ_N-1:0] lock_vec;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (int'(p) == REQ_N - 1) ? '0 : p + PW'(1);
    endfunction

    // Walk downward so the requester closest to rr_ptr is the last one written.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int i = REQ_N - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= REQ_N) idx = idx - REQ_N;
            if (bus.req_valid[idx]) begin
                winner = PW'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        owner_nxt    = owner;
        beat_cnt_nxt = beat_cnt;
        sel          = winner;
        sel_ok       = found;
        ready_vec    = '0;
        lock_vec     = '0;

        if (state == LOCKED) begin
            sel    = owner;
            sel_ok = 1'b1;
        end

        // Reset gating keeps every output quiet while nreset is low.
        grant_ready    = sel_ok & ~bus.fifo_full & nreset;
        ready_vec[sel] = grant_ready;
        xfer           = grant_ready & bus.req_valid[sel];

        case (state)
            IDLE: begin
                if (xfer) begin
                    if (bus.req_last[sel] || BURST_MAX <= 1) begin
                        rr_ptr_nxt = next_ptr(winner);
                    end else begin
                        state_nxt    = LOCKED;
                        owner_nxt    = winner;
                        beat_cnt_nxt = CW'(1);
                    end
                end
            end
            LOCKED: begin
                lock_vec[owner] = nreset;
                if (xfer) begin
                    if (bus.req_last[sel] || (beat_cnt + CW'(1) == CW'(BURST_MAX))) begin
                        state_nxt    = IDLE;
                        rr_ptr_nxt   = next_ptr(owner);
                        beat_cnt_nxt = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            owner    <= owner_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    assign bus.req_ready    = ready_vec;
    assign bus.fifo_wr      = xfer;
    assign bus.fifo_wr_data = xfer ? bus.req_data[int'(sel)*DATA_W +: DATA_W] : '0;
    assign bus.lock         = lock_vec;
    assign bus.busy         = (state == LOCKED) & nreset;
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: REQ_N=4, DATA_W=8, BURST_MAX=4, hand-computed grants.
module tb_fifo_wr_arb;
    logic clk;
    logic nreset;
    int   n_tests;
    int   n_fail;
    int   wr_cnt;

    fifo_wr_arb_if #(.REQ_N(4), .DATA_W(8)) bus ();

    fifo_wr_arb #(.REQ_N(4), .DATA_W(8), .BURST_MAX(4)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setr(input int k, input logic v, input logic [7:0] d, input logic l);
        bus.req_valid[k]       = v;
        bus.req_data[k*8 +: 8] = d;
        bus.req_last[k]        = l;
    endtask

    task automatic clear_all();
        for (int k = 0; k < 4; k++) setr(k, 1'b0, 8'h00, 1'b0);
    endtask

    // Check one cycle mid-period, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic [3:0] e_rdy, input logic e_wr,
                       input logic [7:0] e_dat, input logic e_busy, input logic [3:0] e_lock);
        @(negedge clk);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'(e_rdy));
        chk({tag, "_wr"},    32'(bus.fifo_wr), 32'(e_wr));
        chk({tag, "_data"},  32'(bus.fifo_wr_data), 32'(e_dat));
        chk({tag, "_busy"},  32'(bus.busy), 32'(e_busy));
        chk({tag, "_lock"},  32'(bus.lock), 32'(e_lock));
        if (bus.fifo_wr) wr_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        wr_cnt        = 0;
        nreset        = 1'b0;
        bus.fifo_full = 1'b0;
        clear_all();

        // reset with everything requesting, then single-beat round robin
        for (int k = 0; k < 4; k++) setr(k, 1'b1, 8'hA0 + 8'(k), 1'b1);
        cyc("rst0", 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000);
        cyc("rst1", 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000);
        nreset = 1'b1;
        cyc("rr0", 4'b0001, 1'b1, 8'hA0, 1'b0, 4'b0000);
        cyc("rr1", 4'b0010, 1'b1, 8'hA1, 1'b0, 4'b0000);
        cyc("rr2", 4'b0100, 1'b1, 8'hA2, 1'b0, 4'b0000);
        cyc("rr3", 4'b1000, 1'b1, 8'hA3, 1'b0, 4'b0000);
        cyc("rr4", 4'b0001, 1'b1, 8'hA0, 1'b0, 4'b0000);
        clear_all();

        // req1 three-beat packet against req0/req2 (rr_ptr=1)
        setr(0, 1'b1, 8'h10, 1'b1);
        setr(2, 1'b1, 8'h30, 1'b1);
        setr(1, 1'b1, 8'h1A, 1'b0);
        cyc("pk_a", 4'b0010, 1'b1, 8'h1A, 1'b0, 4'b0000);
        setr(1, 1'b1, 8'h1B, 1'b0);
        cyc("pk_b", 4'b0010, 1'b1, 8'h1B, 1'b1, 4'b0010);
        setr(1, 1'b1, 8'h1C, 1'b1);
        cyc("pk_c", 4'b0010, 1'b1, 8'h1C, 1'b1, 4'b0010);
        setr(1, 1'b0, 8'h00, 1'b0);
        cyc("pk_nx", 4'b0100, 1'b1, 8'h30, 1'b0, 4'b0000);
        clear_all();

        // req0 six-beat packet split by the burst limit, req3 slips in (rr_ptr=3)
        wr_cnt = 0;
        setr(0, 1'b1, 8'h40, 1'b0);
        cyc("bm0", 4'b0001, 1'b1, 8'h40, 1'b0, 4'b0000);
        setr(3, 1'b1, 8'h77, 1'b1);
        setr(0, 1'b1, 8'h41, 1'b0);
        cyc("bm1", 4'b0001, 1'b1, 8'h41, 1'b1, 4'b0001);
        setr(0, 1'b1, 8'h42, 1'b0);
        cyc("bm2", 4'b0001, 1'b1, 8'h42, 1'b1, 4'b0001);
        setr(0, 1'b1, 8'h43, 1'b0);
        cyc("bm3", 4'b0001, 1'b1, 8'h43, 1'b1, 4'b0001);
        setr(0, 1'b1, 8'h44, 1'b0);
        cyc("bm_r3", 4'b1000, 1'b1, 8'h77, 1'b0, 4'b0000);
        setr(3, 1'b0, 8'h00, 1'b0);
        cyc("bm4", 4'b0001, 1'b1, 8'h44, 1'b0, 4'b0000);
        setr(0, 1'b1, 8'h45, 1'b1);
        cyc("bm5", 4'b0001, 1'b1, 8'h45, 1'b1, 4'b0001);
        clear_all();
        chk("bm_wr_cnt", 32'(wr_cnt), 32'd7);

        // full held three cycles mid-packet (rr_ptr=1)
        setr(1, 1'b1, 8'h50, 1'b0);
        cyc("fu0", 4'b0010, 1'b1, 8'h50, 1'b0, 4'b0000);
        bus.fifo_full = 1'b1;
        setr(1, 1'b1, 8'h51, 1'b0);
        setr(2, 1'b1, 8'h60, 1'b1);
        cyc("fu_h0", 4'b0000, 1'b0, 8'h00, 1'b1, 4'b0010);
        cyc("fu_h1", 4'b0000, 1'b0, 8'h00, 1'b1, 4'b0010);
        cyc("fu_h2", 4'b0000, 1'b0, 8'h00, 1'b1, 4'b0010);
        bus.fifo_full = 1'b0;
        cyc("fu1", 4'b0010, 1'b1, 8'h51, 1'b1, 4'b0010);
        setr(1, 1'b1, 8'h52, 1'b0);
        cyc("fu2", 4'b0010, 1'b1, 8'h52, 1'b1, 4'b0010);
        setr(1, 1'b1, 8'h53, 1'b0);
        cyc("fu3", 4'b0010, 1'b1, 8'h53, 1'b1, 4'b0010);
        setr(1, 1'b0, 8'h00, 1'b0);
        cyc("fu_nx", 4'b0100, 1'b1, 8'h60, 1'b0, 4'b0000);
        clear_all();

        // owner stalls two cycles while others request (rr_ptr=3)
        setr(3, 1'b1, 8'h70, 1'b0);
        cyc("st0", 4'b1000, 1'b1, 8'h70, 1'b0, 4'b0000);
        setr(3, 1'b0, 8'h00, 1'b0);
        setr(0, 1'b1, 8'h01, 1'b1);
        setr(1, 1'b1, 8'h11, 1'b1);
        setr(2, 1'b1, 8'h21, 1'b1);
        cyc("st_h0", 4'b1000, 1'b0, 8'h00, 1'b1, 4'b1000);
        cyc("st_h1", 4'b1000, 1'b0, 8'h00, 1'b1, 4'b1000);
        setr(3, 1'b1, 8'h71, 1'b1);
        cyc("st1", 4'b1000, 1'b1, 8'h71, 1'b1, 4'b1000);
        setr(3, 1'b0, 8'h00, 1'b0);
        cyc("st_nx", 4'b0001, 1'b1, 8'h01, 1'b0, 4'b0000);
        clear_all();

        // reset in the middle of a locked packet (rr_ptr=1)
        for (int k = 0; k < 4; k++) setr(k, 1'b1, 8'h80 + 8'(k), 1'b0);
        cyc("rl0", 4'b0010, 1'b1, 8'h81, 1'b0, 4'b0000);
        cyc("rl1", 4'b0010, 1'b1, 8'h81, 1'b1, 4'b0010);
        nreset = 1'b0;
        cyc("rl_r0", 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000);
        cyc("rl_r1", 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000);
        nreset = 1'b1;
        cyc("rl_nx", 4'b0001, 1'b1, 8'h80, 1'b0, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
